// File: rtl/phase_decoder.sv
// phase_decoder: turns the phase of a neuron spike inside each global_phase
// window back into an input-current estimate, THRESHOLD / phase. The estimate
// comes from an 8-step restoring divider. An exponential moving average of the
// estimates is also kept, and each result is presented on a valid/ready output.
module phase_decoder #(
    parameter logic [7:0] THRESHOLD   = 8'd200,
    parameter int         ALPHA_SHIFT = 2,
    parameter logic [7:0] ZERO_EST    = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cycle_start,
    input  logic [7:0] global_phase,
    input  logic       spike_in,
    input  logic       enable,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] current_est,
    output logic [7:0] current_avg,
    output logic       spike_seen,
    output logic [7:0] miss_cnt,
    output logic [7:0] drop_cnt,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state_reg, state_next;
    logic        win_open_reg;
    logic        cap_flag_reg;
    logic [7:0]  cap_phase_reg;
    logic        div_flag_reg;
    logic        skip_reg;
    logic [7:0]  divisor_reg;
    logic [7:0]  quot_reg;
    logic [8:0]  rem_reg;
    logic [2:0]  iter_reg;

    logic        cs_en;
    logic        win_close;
    logic        accept;
    logic        drop;
    logic [8:0]  rem_shift;
    logic [8:0]  rem_next;
    logic [7:0]  quot_next;
    logic signed [8:0] ema_diff;
    logic signed [8:0] ema_step;
    logic signed [9:0] ema_sum;
    logic [7:0]  avg_next;

    // A cycle_start only closes a window once one has been opened; the first
    // pulse after reset or after enable rises just opens a window.
    assign cs_en     = cycle_start & enable;
    assign win_close = cs_en & win_open_reg;
    // The DONE cycle may already take the next window, so only DIV rejects one.
    assign accept    = win_close & (state_reg != DIV);
    assign drop      = win_close & (state_reg == DIV);
    assign busy      = (state_reg == DIV);

    // Track whether a window is currently open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_open_reg <= 1'b0;
        end else if (!enable) begin
            win_open_reg <= 1'b0;
        end else if (cycle_start) begin
            win_open_reg <= 1'b1;
        end
    end

    // Capture the first spike of each window. A spike on the cycle_start clock
    // belongs to the window that this cycle_start opens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_flag_reg  <= 1'b0;
            cap_phase_reg <= 8'd0;
        end else if (cs_en) begin
            cap_flag_reg  <= spike_in;
            cap_phase_reg <= spike_in ? global_phase : 8'd0;
        end else if (enable && spike_in && !cap_flag_reg) begin
            cap_flag_reg  <= 1'b1;
            cap_phase_reg <= global_phase;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state. DIV always lasts 8 clocks, so the latency does not depend
    // on the data.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = DIV;
            DIV:     if (iter_reg == 3'd7) state_next = DONE;
            DONE:    state_next = accept ? DIV : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One restoring-division step. The remainder shifts in the next numerator
    // bit, which is taken from the top of the quotient register.
    always_comb begin
        rem_shift = {rem_reg[7:0], quot_reg[7]};
        rem_next  = rem_shift;
        quot_next = {quot_reg[6:0], 1'b0};
        if (rem_shift >= {1'b0, divisor_reg}) begin
            rem_next  = rem_shift - {1'b0, divisor_reg};
            quot_next = {quot_reg[6:0], 1'b1};
        end
    end

    // Divider datapath. The special cases preload the final result and skip
    // the iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_flag_reg <= 1'b0;
            skip_reg     <= 1'b0;
            divisor_reg  <= 8'd0;
            quot_reg     <= 8'd0;
            rem_reg      <= 9'd0;
            iter_reg     <= 3'd0;
        end else if (accept) begin
            div_flag_reg <= cap_flag_reg;
            divisor_reg  <= cap_phase_reg;
            rem_reg      <= 9'd0;
            iter_reg     <= 3'd0;
            if (!cap_flag_reg) begin
                quot_reg <= 8'd0;
                skip_reg <= 1'b1;
            end else if (cap_phase_reg == 8'd0) begin
                quot_reg <= ZERO_EST;
                skip_reg <= 1'b1;
            end else begin
                quot_reg <= THRESHOLD;
                skip_reg <= 1'b0;
            end
        end else if (state_reg == DIV) begin
            iter_reg <= iter_reg + 3'd1;
            if (!skip_reg) begin
                rem_reg  <= rem_next;
                quot_reg <= quot_next;
            end
        end
    end

    // EMA update: avg + ((est - avg) >>> ALPHA_SHIFT), clamped to 0..255.
    always_comb begin
        ema_diff = $signed({1'b0, quot_reg}) - $signed({1'b0, current_avg});
        ema_step = ema_diff >>> ALPHA_SHIFT;
        ema_sum  = $signed({2'b00, current_avg}) + $signed({ema_step[8], ema_step});
        avg_next = ema_sum[7:0];
        if (ema_sum < 0) begin
            avg_next = 8'd0;
        end else if (ema_sum > 10'sd255) begin
            avg_next = 8'd255;
        end
    end

    // Result register and valid/ready handshake. If a new result lands on an
    // unaccepted one, the old result is overwritten and the overrun is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            current_est <= 8'd0;
            current_avg <= 8'd0;
            spike_seen  <= 1'b0;
            overrun     <= 1'b0;
        end else if (state_reg == DONE) begin
            current_est <= quot_reg;
            current_avg <= avg_next;
            spike_seen  <= div_flag_reg;
            out_valid   <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating counters for empty windows and for windows lost to a busy divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (win_close && !cap_flag_reg && miss_cnt != 8'd255) begin
                miss_cnt <= miss_cnt + 8'd1;
            end
            if (drop && drop_cnt != 8'd255) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_phase_decoder.sv
// Testbench for phase_decoder. It uses directed windows. Each accepted window
// close pushes the expected {spike_seen, avg, est} onto a scoreboard queue.
// The entry is popped and compared when the decoder presents the result.
module tb_phase_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cycle_start = 1'b0;
    logic [7:0] global_phase = 8'd0;
    logic       spike_in = 1'b0;
    logic       enable = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] current_est;
    logic [7:0] current_avg;
    logic       spike_seen;
    logic [7:0] miss_cnt;
    logic [7:0] drop_cnt;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] sb[$];
    int avg_m  = 0;
    int miss_m = 0;
    int drop_m = 0;
    bit tb_flag = 1'b0;
    int tb_phase = 0;

    phase_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cycle_start  (cycle_start),
        .global_phase (global_phase),
        .spike_in     (spike_in),
        .enable       (enable),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .current_est  (current_est),
        .current_avg  (current_avg),
        .spike_seen   (spike_seen),
        .miss_cnt     (miss_cnt),
        .drop_cnt     (drop_cnt),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int est_of(input bit f, input int ph);
        if (!f) return 0;
        if (ph == 0) return 255;
        return 200 / ph;
    endfunction

    task automatic spike(input int ph);
        global_phase = 8'(ph);
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        if (!tb_flag) begin
            tb_flag = 1'b1;
            tb_phase = ph;
        end
    endtask

    task automatic pulse_open();
        cycle_start = 1'b1;
        step();
        cycle_start = 1'b0;
        tb_flag = 1'b0;
        tb_phase = 0;
    endtask

    // Close the current window. The spike/phase arguments give a spike that
    // coincides with this cycle_start.
    task automatic close_win(input bit accepted, input bit spk = 1'b0, input int ph = 0);
        int e;
        int d;
        logic [7:0] e8;
        logic [7:0] a8;
        if (!tb_flag) miss_m = (miss_m < 255) ? miss_m + 1 : 255;
        if (accepted) begin
            e = est_of(tb_flag, tb_phase);
            d = (e - avg_m) >>> 2;
            avg_m = avg_m + d;
            if (avg_m < 0) avg_m = 0;
            if (avg_m > 255) avg_m = 255;
            e8 = 8'(e);
            a8 = 8'(avg_m);
            sb.push_back({tb_flag, a8, e8});
        end else begin
            drop_m = (drop_m < 255) ? drop_m + 1 : 255;
        end
        global_phase = 8'(ph);
        spike_in = spk;
        cycle_start = 1'b1;
        step();
        cycle_start = 1'b0;
        spike_in = 1'b0;
        tb_flag = spk;
        tb_phase = ph;
    endtask

    task automatic compare_result(input string tag);
        logic [16:0] exp;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
            return;
        end
        exp = sb.pop_front();
        check({tag, "_est"},  32'(current_est), 32'(exp[7:0]));
        check({tag, "_avg"},  32'(current_avg), 32'(exp[15:8]));
        check({tag, "_seen"}, 32'(spike_seen),  32'(exp[16]));
    endtask

    // Called right after the close edge. It waits for out_valid with a bound.
    task automatic expect_result(input string tag, input bit chk_lat);
        int lat = 0;
        int busy_n = 0;
        while (!out_valid && lat < 30) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (chk_lat) begin
            check({tag, "_lat"},  32'(lat),    32'd9);
            check({tag, "_busy"}, 32'(busy_n), 32'd8);
        end
        compare_result(tag);
    endtask

    initial begin
        int saw;

        // Reset state
        step(2);
        check("rst_valid",   32'(out_valid),   32'd0);
        check("rst_est",     32'(current_est), 32'd0);
        check("rst_avg",     32'(current_avg), 32'd0);
        check("rst_seen",    32'(spike_seen),  32'd0);
        check("rst_miss",    32'(miss_cnt),    32'd0);
        check("rst_drop",    32'(drop_cnt),    32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        rst_n = 1'b1;
        step();

        // The first cycle_start only opens a window
        enable = 1'b1;
        out_ready = 1'b1;
        pulse_open();
        step(2);
        check("open_busy",  32'(busy),      32'd0);
        check("open_valid", 32'(out_valid), 32'd0);

        spike(50);
        close_win(1'b1);
        expect_result("ph50", 1'b1);

        spike(1);
        close_win(1'b1);
        expect_result("ph1", 1'b1);

        spike(0);
        close_win(1'b1);
        expect_result("ph0", 1'b1);

        step(2);
        close_win(1'b1);
        expect_result("empty", 1'b1);
        check("miss_one", 32'(miss_cnt), 32'(miss_m));

        spike(20);
        step();
        spike(40);
        close_win(1'b1);
        expect_result("two_spk", 1'b1);

        // A spike coincident with cycle_start goes to the new window
        close_win(1'b1, 1'b1, 0);
        expect_result("coin_old", 1'b0);
        step(2);
        close_win(1'b1);
        expect_result("coin_new", 1'b1);

        // Overrun: two results arrive while out_ready is held low
        step();
        out_ready = 1'b0;
        spike(100);
        close_win(1'b1);
        expect_result("ovr_a", 1'b1);
        step(2);
        check("ovr_hold_est", 32'(current_est), 32'd2);
        spike(25);
        close_win(1'b1);
        step(4);
        check("ovr_stable_est", 32'(current_est), 32'd2);
        check("ovr_pre_flag",   32'(overrun),     32'd0);
        step(5);
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_flag",  32'(overrun),   32'd1);
        compare_result("ovr_b");
        out_ready = 1'b1;
        step();
        check("ovr_consumed", 32'(out_valid), 32'd0);
        check("ovr_sticky",   32'(overrun),   32'd1);

        // Windows closed while the divider is busy are dropped
        spike(10);
        close_win(1'b1);
        step(3);
        close_win(1'b0);
        step(3);
        close_win(1'b0);
        expect_result("drop", 1'b0);
        check("drop_cnt", 32'(drop_cnt), 32'(drop_m));
        check("drop_miss", 32'(miss_cnt), 32'(miss_m));

        // With enable low, a cycle_start neither decodes nor counts
        step();
        enable = 1'b0;
        cycle_start = 1'b1;
        step();
        cycle_start = 1'b0;
        step(3);
        check("dis_busy",  32'(busy),      32'd0);
        check("dis_valid", 32'(out_valid), 32'd0);
        check("dis_miss",  32'(miss_cnt),  32'(miss_m));
        enable = 1'b1;
        pulse_open();
        spike(40);
        close_win(1'b1);
        expect_result("reen", 1'b1);

        // Hold cycle_start high so the counters saturate
        cycle_start = 1'b1;
        step(300);
        cycle_start = 1'b0;
        step(15);
        check("sat_miss", 32'(miss_cnt), 32'd255);
        check("sat_drop", 32'(drop_cnt), 32'd255);
        sb.delete();

        // An asynchronous reset in the middle of a division aborts it
        spike(60);
        close_win(1'b1);
        step(3);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",    32'(busy),        32'd0);
        check("arst_valid",   32'(out_valid),   32'd0);
        check("arst_est",     32'(current_est), 32'd0);
        check("arst_avg",     32'(current_avg), 32'd0);
        check("arst_miss",    32'(miss_cnt),    32'd0);
        check("arst_drop",    32'(drop_cnt),    32'd0);
        check("arst_overrun", 32'(overrun),     32'd0);
        #2 rst_n = 1'b1;
        sb.delete();
        saw = 0;
        repeat (15) begin
            step();
            if (out_valid) saw = 1;
        end
        check("arst_no_valid", 32'(saw), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
